// File: rtl/ahb3lite_master_arbiter_pkg.sv
// Shared AHB3-Lite encodings and arbiter types for the multi-master arbiter slice.
package ahb3lite_master_arbiter_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      ARB_PARK,
      ARB_ACTIVE,
      ARB_LOCKED
   } arb_state_t;

   function automatic logic is_xfer(input logic [1:0] i_trans);
      return (i_trans == HTRANS_NONSEQ) || (i_trans == HTRANS_SEQ);
   endfunction

endpackage

// File: rtl/ahb3lite_rr_picker.sv
// Combinational round-robin picker: first requester strictly after the last winner.
module ahb3lite_rr_picker #(
   parameter int N  = 3,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_rr_ptr,
   output logic [N-1:0]  o_winner,
   output logic          o_found
);

   // NOTE: every output gets a default before the search loop so no latch is inferred.
   always_comb begin
      o_winner = '0;
      o_found  = 1'b0;
      for (int k = 1; k <= N; k++) begin
         if (!o_found && i_req[(int'(i_rr_ptr) + k) % N]) begin
            o_winner[(int'(i_rr_ptr) + k) % N] = 1'b1;
            o_found                             = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ahb3lite_master_arbiter.sv
// Round-robin AHB3-Lite multi-master arbiter with address/data phase owner tracking and lock support.
module ahb3lite_master_arbiter
   import ahb3lite_master_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS = 3,
   parameter int HADDR_SIZE  = 32,
   parameter int HDATA_SIZE  = 32
) (
   input  logic                              HCLK,
   input  logic                              HRESET,
   input  logic [NUM_MASTERS*2-1:0]          m_HTRANS,
   input  logic [NUM_MASTERS*HADDR_SIZE-1:0] m_HADDR,
   input  logic [NUM_MASTERS-1:0]            m_HWRITE,
   input  logic [NUM_MASTERS*3-1:0]          m_HSIZE,
   input  logic [NUM_MASTERS*3-1:0]          m_HBURST,
   input  logic [NUM_MASTERS*4-1:0]          m_HPROT,
   input  logic [NUM_MASTERS-1:0]            m_HMASTLOCK,
   input  logic [NUM_MASTERS*HDATA_SIZE-1:0] m_HWDATA,
   output logic [NUM_MASTERS-1:0]            m_HREADY,
   output logic [NUM_MASTERS-1:0]            m_HRESP,
   output logic [HDATA_SIZE-1:0]             m_HRDATA,
   output logic [NUM_MASTERS-1:0]            m_grant,
   output logic [1:0]                        S_HTRANS,
   output logic [HADDR_SIZE-1:0]             S_HADDR,
   output logic                              S_HWRITE,
   output logic [2:0]                        S_HSIZE,
   output logic [2:0]                        S_HBURST,
   output logic [3:0]                        S_HPROT,
   output logic                              S_HMASTLOCK,
   output logic [HDATA_SIZE-1:0]             S_HWDATA,
   input  logic                              S_HREADY,
   input  logic                              S_HRESP,
   input  logic [HDATA_SIZE-1:0]             S_HRDATA
);

   localparam int IW = $clog2(NUM_MASTERS);

   logic [IW-1:0]          r_owner, r_d_owner, r_rr_ptr, w_win_idx;
   logic                   r_d_valid;
   arb_state_t             r_state, w_next_state;
   logic [NUM_MASTERS-1:0] w_req, w_win_oh;
   logic                   w_found, w_release;

   assign S_HTRANS    = m_HTRANS[int'(r_owner)*2 +: 2];
   assign S_HADDR     = m_HADDR[int'(r_owner)*HADDR_SIZE +: HADDR_SIZE];
   assign S_HWRITE    = m_HWRITE[r_owner];
   assign S_HSIZE     = m_HSIZE[int'(r_owner)*3 +: 3];
   assign S_HBURST    = m_HBURST[int'(r_owner)*3 +: 3];
   assign S_HPROT     = m_HPROT[int'(r_owner)*4 +: 4];
   assign S_HMASTLOCK = m_HMASTLOCK[r_owner];
   assign S_HWDATA    = m_HWDATA[int'(r_d_owner)*HDATA_SIZE +: HDATA_SIZE];
   assign m_HRDATA    = S_HRDATA;

   // Only an idle, unlocked owner on a completed cycle gives the bus up; BUSY/SEQ keep bursts intact.
   assign w_release = S_HREADY && (S_HTRANS == HTRANS_IDLE) && !S_HMASTLOCK;

   always_comb begin
      w_req = '0;
      for (int i = 0; i < NUM_MASTERS; i++)
         w_req[i] = (m_HTRANS[i*2 +: 2] == HTRANS_NONSEQ) && (IW'(i) != r_owner);
   end

   ahb3lite_rr_picker #(.N(NUM_MASTERS), .IW(IW)) u_picker (
      .i_req    (w_req),
      .i_rr_ptr (r_rr_ptr),
      .o_winner (w_win_oh),
      .o_found  (w_found)
   );

   always_comb begin
      w_win_idx = '0;
      for (int i = 0; i < NUM_MASTERS; i++)
         if (w_win_oh[i]) w_win_idx = IW'(i);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) r_state <= ARB_PARK;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      if (S_HREADY) begin
         case (r_state)
            ARB_PARK:   if (S_HTRANS == HTRANS_NONSEQ)
                           w_next_state = S_HMASTLOCK ? ARB_LOCKED : ARB_ACTIVE;
            ARB_ACTIVE: if (S_HMASTLOCK)    w_next_state = ARB_LOCKED;
                        else if (w_release) w_next_state = ARB_PARK;
            ARB_LOCKED: if (!S_HMASTLOCK)
                           w_next_state = (S_HTRANS == HTRANS_IDLE) ? ARB_PARK : ARB_ACTIVE;
            default:    w_next_state = ARB_PARK;
         endcase
      end
   end

   always_comb begin
      m_HREADY = '1;
      m_HRESP  = '0;
      m_grant  = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (IW'(i) == r_owner)                     m_HREADY[i] = S_HREADY;
         else if (r_d_valid && IW'(i) == r_d_owner) m_HREADY[i] = S_HREADY;
         else if (is_xfer(m_HTRANS[i*2 +: 2]))      m_HREADY[i] = 1'b0;
         m_HRESP[i] = (IW'(i) == r_owner || IW'(i) == r_d_owner) ? S_HRESP : HRESP_OKAY;
         m_grant[i] = (IW'(i) == r_owner);
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_owner   <= '0;
         r_d_owner <= '0;
         r_d_valid <= 1'b0;
         r_rr_ptr  <= IW'(NUM_MASTERS - 1);
      end else if (S_HREADY) begin
         r_d_owner <= r_owner;
         r_d_valid <= is_xfer(S_HTRANS);
         if (w_release && w_found) begin
            r_owner  <= w_win_idx;
            r_rr_ptr <= w_win_idx;
         end
      end
   end

endmodule

// File: tb/tb_ahb3lite_master_arbiter.sv
// Directed self-checking bench for the round-robin AHB3-Lite master arbiter (3 masters).
module tb_ahb3lite_master_arbiter;
   import ahb3lite_master_arbiter_pkg::*;

   localparam int N  = 3;
   localparam int AW = 32;
   localparam int DW = 32;

   logic            HCLK, HRESET;
   logic [N*2-1:0]  m_HTRANS;
   logic [N*AW-1:0] m_HADDR;
   logic [N-1:0]    m_HWRITE, m_HMASTLOCK;
   logic [N*3-1:0]  m_HSIZE, m_HBURST;
   logic [N*4-1:0]  m_HPROT;
   logic [N*DW-1:0] m_HWDATA;
   logic [N-1:0]    m_HREADY, m_HRESP, m_grant;
   logic [DW-1:0]   m_HRDATA;
   logic [1:0]      S_HTRANS;
   logic [AW-1:0]   S_HADDR;
   logic            S_HWRITE, S_HMASTLOCK;
   logic [2:0]      S_HSIZE, S_HBURST;
   logic [3:0]      S_HPROT;
   logic [DW-1:0]   S_HWDATA, S_HRDATA;
   logic            S_HREADY, S_HRESP;

   int n_cmp = 0;
   int n_err = 0;

   ahb3lite_master_arbiter #(.NUM_MASTERS(N), .HADDR_SIZE(AW), .HDATA_SIZE(DW)) dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .m_HTRANS(m_HTRANS), .m_HADDR(m_HADDR), .m_HWRITE(m_HWRITE), .m_HSIZE(m_HSIZE),
      .m_HBURST(m_HBURST), .m_HPROT(m_HPROT), .m_HMASTLOCK(m_HMASTLOCK), .m_HWDATA(m_HWDATA),
      .m_HREADY(m_HREADY), .m_HRESP(m_HRESP), .m_HRDATA(m_HRDATA), .m_grant(m_grant),
      .S_HTRANS(S_HTRANS), .S_HADDR(S_HADDR), .S_HWRITE(S_HWRITE), .S_HSIZE(S_HSIZE),
      .S_HBURST(S_HBURST), .S_HPROT(S_HPROT), .S_HMASTLOCK(S_HMASTLOCK), .S_HWDATA(S_HWDATA),
      .S_HREADY(S_HREADY), .S_HRESP(S_HRESP), .S_HRDATA(S_HRDATA)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge HCLK);
      #1;
   endtask

   task automatic drv(input int m, input logic [1:0] t, input logic [31:0] a, input logic w, input logic lk);
      m_HTRANS[m*2 +: 2]   = t;
      m_HADDR[m*AW +: AW]  = a;
      m_HWRITE[m]          = w;
      m_HMASTLOCK[m]       = lk;
   endtask

   task automatic do_reset;
      HRESET      = 1'b1;
      m_HTRANS    = '0;
      m_HADDR     = '0;
      m_HWRITE    = '0;
      m_HMASTLOCK = '0;
      m_HSIZE     = {N{3'b010}};
      m_HBURST    = '0;
      m_HPROT     = {N{4'b0011}};
      m_HWDATA    = '0;
      S_HREADY    = 1'b1;
      S_HRESP     = 1'b0;
      S_HRDATA    = '0;
      tick();
      tick();
      HRESET = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      drv(0, HTRANS_IDLE, 32'h0000_00AA, 1'b0, 1'b0);
      #1;
      n_cmp++; if (m_grant !== 3'b001) begin n_err++; $display("FAIL rst_grant got=%b exp=001", m_grant); end
      n_cmp++; if (m_HREADY !== 3'b111) begin n_err++; $display("FAIL rst_hready got=%b exp=111", m_HREADY); end
      n_cmp++; if (m_HRESP !== 3'b000) begin n_err++; $display("FAIL rst_hresp got=%b exp=000", m_HRESP); end
      n_cmp++; if (S_HADDR !== 32'h0000_00AA) begin n_err++; $display("FAIL rst_haddr got=%h exp=000000aa", S_HADDR); end
      n_cmp++; if (S_HTRANS !== HTRANS_IDLE) begin n_err++; $display("FAIL rst_htrans got=%b exp=00", S_HTRANS); end
   endtask

   task automatic test_single_read;
      do_reset();
      drv(1, HTRANS_NONSEQ, 32'h0000_1000, 1'b0, 1'b0);
      #1;
      n_cmp++; if (m_grant !== 3'b001) begin n_err++; $display("FAIL t1_park_grant got=%b exp=001", m_grant); end
      n_cmp++; if (S_HTRANS !== HTRANS_IDLE) begin n_err++; $display("FAIL t1_park_htrans got=%b exp=00", S_HTRANS); end
      n_cmp++; if (m_HREADY !== 3'b101) begin n_err++; $display("FAIL t1_park_hready got=%b exp=101", m_HREADY); end
      tick();
      n_cmp++; if (m_grant !== 3'b010) begin n_err++; $display("FAIL t1_grant got=%b exp=010", m_grant); end
      n_cmp++; if (S_HADDR !== 32'h0000_1000) begin n_err++; $display("FAIL t1_haddr got=%h exp=00001000", S_HADDR); end
      n_cmp++; if (S_HTRANS !== HTRANS_NONSEQ) begin n_err++; $display("FAIL t1_htrans got=%b exp=10", S_HTRANS); end
      n_cmp++; if (m_HREADY !== 3'b111) begin n_err++; $display("FAIL t1_addr_hready got=%b exp=111", m_HREADY); end
      tick();
      drv(1, HTRANS_IDLE, 32'h0, 1'b0, 1'b0);
      S_HRDATA = 32'hA5A5_A5A5;
      #1;
      n_cmp++; if (m_HRDATA !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL t1_hrdata got=%h exp=a5a5a5a5", m_HRDATA); end
      n_cmp++; if (m_HREADY !== 3'b111) begin n_err++; $display("FAIL t1_data_hready got=%b exp=111", m_HREADY); end
      tick();
      S_HRDATA = '0;
      #1;
      n_cmp++; if (m_grant !== 3'b010) begin n_err++; $display("FAIL t1_parked_on_m1 got=%b exp=010", m_grant); end
   endtask

   task automatic test_round_robin;
      logic [2:0]  exp_grant [6];
      logic [2:0]  exp_rdy   [6];
      logic [31:0] exp_addr  [6];
      exp_grant = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
      exp_rdy   = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b110, 3'b110};
      exp_addr  = '{32'h100, 32'h0, 32'h110, 32'h0, 32'h120, 32'h0};
      do_reset();
      drv(0, HTRANS_NONSEQ, 32'h100, 1'b0, 1'b0);
      drv(1, HTRANS_NONSEQ, 32'h110, 1'b0, 1'b0);
      drv(2, HTRANS_NONSEQ, 32'h120, 1'b0, 1'b0);
      for (int c = 0; c < 6; c++) begin
         if (c > 0) tick();
         case (c)
            1: drv(0, HTRANS_IDLE,   32'h0,   1'b0, 1'b0);
            2: drv(0, HTRANS_NONSEQ, 32'h104, 1'b0, 1'b0);
            3: drv(1, HTRANS_IDLE,   32'h0,   1'b0, 1'b0);
            5: drv(2, HTRANS_IDLE,   32'h0,   1'b0, 1'b0);
            default: ;
         endcase
         #1;
         n_cmp++; if (m_grant !== exp_grant[c]) begin n_err++; $display("FAIL t2_grant c=%0d got=%b exp=%b", c, m_grant, exp_grant[c]); end
         n_cmp++; if (m_HREADY !== exp_rdy[c]) begin n_err++; $display("FAIL t2_hready c=%0d got=%b exp=%b", c, m_HREADY, exp_rdy[c]); end
         if (c % 2 == 0) begin
            n_cmp++; if (S_HADDR !== exp_addr[c]) begin n_err++; $display("FAIL t2_haddr c=%0d got=%h exp=%h", c, S_HADDR, exp_addr[c]); end
         end
      end
      tick();
      n_cmp++; if (m_grant !== 3'b001) begin n_err++; $display("FAIL t2_back_to_m0 got=%b exp=001", m_grant); end
      n_cmp++; if (S_HADDR !== 32'h104) begin n_err++; $display("FAIL t2_m0_haddr got=%h exp=00000104", S_HADDR); end
   endtask

   task automatic test_burst;
      logic [31:0] exp_wd;
      logic [31:0] exp_ad;
      do_reset();
      m_HBURST[2:0] = 3'b011;
      drv(0, HTRANS_NONSEQ, 32'h200, 1'b1, 1'b0);
      drv(1, HTRANS_NONSEQ, 32'h300, 1'b0, 1'b0);
      #1;
      n_cmp++; if (S_HBURST !== 3'b011) begin n_err++; $display("FAIL t3_hburst got=%b exp=011", S_HBURST); end
      n_cmp++; if (S_HADDR !== 32'h200) begin n_err++; $display("FAIL t3_haddr0 got=%h exp=00000200", S_HADDR); end
      for (int beat = 1; beat <= 4; beat++) begin
         tick();
         exp_ad = 32'h200 + 32'(4 * beat);
         exp_wd = 32'hD000_0000 + 32'(beat - 1);
         if (beat < 4) drv(0, HTRANS_SEQ, exp_ad, 1'b1, 1'b0);
         else          drv(0, HTRANS_IDLE, 32'h0, 1'b0, 1'b0);
         m_HWDATA[0 +: DW] = exp_wd;
         #1;
         n_cmp++; if (m_grant !== 3'b001) begin n_err++; $display("FAIL t3_grant beat=%0d got=%b exp=001", beat, m_grant); end
         n_cmp++; if (S_HWDATA !== exp_wd) begin n_err++; $display("FAIL t3_hwdata beat=%0d got=%h exp=%h", beat, S_HWDATA, exp_wd); end
         n_cmp++; if (m_HREADY[1] !== 1'b0) begin n_err++; $display("FAIL t3_m1_stall beat=%0d got=%b exp=0", beat, m_HREADY[1]); end
         if (beat < 4) begin
            n_cmp++; if (S_HADDR !== exp_ad) begin n_err++; $display("FAIL t3_haddr beat=%0d got=%h exp=%h", beat, S_HADDR, exp_ad); end
         end
      end
      tick();
      n_cmp++; if (m_grant !== 3'b010) begin n_err++; $display("FAIL t3_m1_grant got=%b exp=010", m_grant); end
      n_cmp++; if (S_HADDR !== 32'h300) begin n_err++; $display("FAIL t3_m1_haddr got=%h exp=00000300", S_HADDR); end
   endtask

   task automatic test_locked;
      do_reset();
      drv(2, HTRANS_NONSEQ, 32'h40, 1'b1, 1'b1);
      tick();
      drv(0, HTRANS_NONSEQ, 32'h50, 1'b0, 1'b0);
      #1;
      n_cmp++; if (m_grant !== 3'b100) begin n_err++; $display("FAIL t4_grant got=%b exp=100", m_grant); end
      n_cmp++; if (S_HMASTLOCK !== 1'b1) begin n_err++; $display("FAIL t4_lock got=%b exp=1", S_HMASTLOCK); end
      tick();
      drv(2, HTRANS_IDLE, 32'h0, 1'b0, 1'b1);
      for (int c = 0; c < 3; c++) begin
         if (c > 0) tick();
         #1;
         n_cmp++; if (m_grant !== 3'b100) begin n_err++; $display("FAIL t4_locked_grant c=%0d got=%b exp=100", c, m_grant); end
         n_cmp++; if (m_HREADY[0] !== 1'b0) begin n_err++; $display("FAIL t4_m0_stall c=%0d got=%b exp=0", c, m_HREADY[0]); end
      end
      drv(2, HTRANS_IDLE, 32'h0, 1'b0, 1'b0);
      tick();
      n_cmp++; if (m_grant !== 3'b001) begin n_err++; $display("FAIL t4_m0_grant got=%b exp=001", m_grant); end
      n_cmp++; if (S_HADDR !== 32'h50) begin n_err++; $display("FAIL t4_m0_haddr got=%h exp=00000050", S_HADDR); end
   endtask

   task automatic test_error;
      do_reset();
      drv(1, HTRANS_NONSEQ, 32'h1000, 1'b0, 1'b0);
      tick();
      tick();
      drv(1, HTRANS_IDLE, 32'h0, 1'b0, 1'b0);
      S_HREADY = 1'b0;
      for (int w = 0; w < 3; w++) begin
         #1;
         n_cmp++; if (m_HREADY[1] !== 1'b0) begin n_err++; $display("FAIL t5_wait_hready w=%0d got=%b exp=0", w, m_HREADY[1]); end
         n_cmp++; if (m_HRESP !== 3'b000) begin n_err++; $display("FAIL t5_wait_hresp w=%0d got=%b exp=000", w, m_HRESP); end
         n_cmp++; if (m_grant !== 3'b010) begin n_err++; $display("FAIL t5_wait_grant w=%0d got=%b exp=010", w, m_grant); end
         tick();
      end
      S_HRESP = 1'b1;
      drv(0, HTRANS_NONSEQ, 32'h80, 1'b0, 1'b0);
      #1;
      n_cmp++; if (m_HREADY[1] !== 1'b0) begin n_err++; $display("FAIL t5_err1_hready got=%b exp=0", m_HREADY[1]); end
      n_cmp++; if (m_HRESP !== 3'b010) begin n_err++; $display("FAIL t5_err1_hresp got=%b exp=010", m_HRESP); end
      tick();
      S_HREADY = 1'b1;
      #1;
      n_cmp++; if (m_HREADY[1] !== 1'b1) begin n_err++; $display("FAIL t5_err2_hready got=%b exp=1", m_HREADY[1]); end
      n_cmp++; if (m_HRESP !== 3'b010) begin n_err++; $display("FAIL t5_err2_hresp got=%b exp=010", m_HRESP); end
      tick();
      S_HRESP = 1'b0;
      #1;
      n_cmp++; if (m_grant !== 3'b001) begin n_err++; $display("FAIL t5_handover got=%b exp=001", m_grant); end
      n_cmp++; if (S_HADDR !== 32'h80) begin n_err++; $display("FAIL t5_m0_haddr got=%h exp=00000080", S_HADDR); end
   endtask

   task automatic test_reset_mid;
      do_reset();
      drv(1, HTRANS_NONSEQ, 32'h1000, 1'b0, 1'b0);
      tick();
      tick();
      drv(1, HTRANS_NONSEQ, 32'h1004, 1'b0, 1'b0);
      drv(0, HTRANS_IDLE, 32'hDEAD_0000, 1'b0, 1'b0);
      S_HREADY = 1'b0;
      #1;
      n_cmp++; if (m_grant !== 3'b010) begin n_err++; $display("FAIL t6_pre_grant got=%b exp=010", m_grant); end
      #2;
      HRESET = 1'b1;
      #1;
      n_cmp++; if (m_grant !== 3'b001) begin n_err++; $display("FAIL t6_async_grant got=%b exp=001", m_grant); end
      n_cmp++; if (S_HADDR !== 32'hDEAD_0000) begin n_err++; $display("FAIL t6_async_haddr got=%h exp=dead0000", S_HADDR); end
      n_cmp++; if (S_HTRANS !== HTRANS_IDLE) begin n_err++; $display("FAIL t6_async_htrans got=%b exp=00", S_HTRANS); end
      n_cmp++; if (dut.r_state !== ARB_PARK) begin n_err++; $display("FAIL t6_async_state got=%0d exp=%0d", dut.r_state, ARB_PARK); end
      S_HREADY = 1'b1;
      #1;
      n_cmp++; if (m_HREADY !== 3'b101) begin n_err++; $display("FAIL t6_dvalid_clear got=%b exp=101", m_HREADY); end
      tick();
      HRESET = 1'b0;
      tick();
      n_cmp++; if (m_grant !== 3'b010) begin n_err++; $display("FAIL t6_regrant got=%b exp=010", m_grant); end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_burst();
      test_locked();
      test_error();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
